// File: rtl/seg7_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_pkg                                                           |
// | Shared glyph table and segment bit constants for the 7-seg driver. |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package seg7_pkg;

    localparam int SEG_A_BIT  = 0;
    localparam int SEG_B_BIT  = 1;
    localparam int SEG_C_BIT  = 2;
    localparam int SEG_D_BIT  = 3;
    localparam int SEG_E_BIT  = 4;
    localparam int SEG_F_BIT  = 5;
    localparam int SEG_G_BIT  = 6;
    localparam int SEG_DP_BIT = 7;

    // Active-low byte values: all segments dark, and the dp bit mask.
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] SEG_DP  = 8'h80;

    // Active-low glyphs for 0..F with dp off.
    localparam logic [7:0] GLYPHS [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage
`default_nettype wire

// File: rtl/seg7_encode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_encode                                                        |
// | Nibble + decimal point -> 8-bit segment byte with polarity select. |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module seg7_encode
    import seg7_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [7:0] w_low;

    always_comb begin
        w_low = GLYPHS[nibble];
        if (dp) begin
            w_low[SEG_DP_BIT] = 1'b0;
        end
    end

    assign seg = (ACTIVE_LOW != 0) ? w_low : ~w_low;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_scan_driver                                                   |
// | Multiplexed N-digit 7-seg scanner with dead time, LZB, snapshots.  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int DEAD_CYCLES    = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   hex_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      lzb_en,
    output logic [7:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic                      frame_tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      C_CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      C_IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]            C_SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] C_AN_OFF   = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                       : {NUM_DIGITS{1'b0}};

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_load_pending;
    logic [4*NUM_DIGITS-1:0] r_hex;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_en;
    logic                    r_lzb;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_dead;
    logic [4*NUM_DIGITS-1:0] w_hex;
    logic [NUM_DIGITS-1:0]   w_dp;
    logic [NUM_DIGITS-1:0]   w_en;
    logic                    w_lzb;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [3:0]              w_nib;
    logic                    w_dp_sel;
    logic                    w_lit;
    logic [7:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_onehot;

    assign w_slot_end  = (r_cnt == C_CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == C_IDX_LAST);

    generate
        if (DEAD_CYCLES > 0) begin : g_dead
            assign w_dead = (r_cnt < CNT_W'(DEAD_CYCLES));
        end else begin : g_no_dead
            assign w_dead = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_pending <= 1'b1;
            r_hex          <= '0;
            r_dp           <= '0;
            r_en           <= '0;
            r_lzb          <= 1'b0;
        end else begin
            r_load_pending <= 1'b0;
            if (r_load_pending || w_frame_end) begin
                r_hex <= hex_in;
                r_dp  <= dp_in;
                r_en  <= digit_en;
                r_lzb <= lzb_en;
            end
        end
    end

    // On the first post-reset cycle the snapshot is being loaded, so use the live inputs.
    assign w_hex = r_load_pending ? hex_in   : r_hex;
    assign w_dp  = r_load_pending ? dp_in    : r_dp;
    assign w_en  = r_load_pending ? digit_en : r_en;
    assign w_lzb = r_load_pending ? lzb_en   : r_lzb;

    always_comb begin
        logic run;
        w_blank = '0;
        run     = w_lzb;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run        = run && (w_hex[4*k +: 4] == 4'h0) && !w_dp[k];
            w_blank[k] = run;
        end
    end

    assign w_nib    = w_hex[r_idx*4 +: 4];
    assign w_dp_sel = w_dp[r_idx];
    assign w_lit    = !w_dead && w_en[r_idx] && !w_blank[r_idx];
    assign w_onehot = NUM_DIGITS'(1) << r_idx;

    seg7_encode #(
        .ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_encode (
        .nibble (w_nib),
        .dp     (w_dp_sel),
        .seg    (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out    <= C_SEG_OFF;
            an_out     <= C_AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            seg_out    <= w_lit ? w_seg : C_SEG_OFF;
            an_out     <= w_lit ? (w_onehot ^ C_AN_OFF) : C_AN_OFF;
            frame_tick <= (r_cnt == '0) && (r_idx == '0);
        end
    end

endmodule
`default_nettype wire
